fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/response bundle between the fetch unit (master)
// and the instruction memory (slave).
//   imem_req   : fetch request valid                 (master -> slave)
//   imem_addr  : fetch address, equals PCF           (master -> slave)
//   imem_ready : imem_rdata valid for this imem_addr (slave -> master)
//   imem_rdata : fetched instruction word            (slave -> master)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding a single IF/ID slot. Fetches from PCF over
// the imem interface, parks a word in a one-entry hold buffer when decode is
// stalled, and supports redirects, flushes and a terminal halt.
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : asynchronous active-high reset
//   imem        : instruction-memory bundle (master side)
//   PCSrc       : redirect request; PCTarget is the new PC
//   PCTarget    : redirect target
//   Stall       : decode cannot accept a new instruction this cycle
//   Flush       : invalidate the IF/ID slot
//   Finish_Prog : instruction in the IF/ID slot ends the program
//   InstrD      : IF/ID instruction, NOP_INSTR when ValidD=0
//   PCD         : PC of InstrD
//   PCPlus4D    : PCD + 4
//   ValidD      : IF/ID slot holds a real instruction
//   Halted      : program finished, fetch stopped until reset
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_FETCH | request outstanding at PCF every cycle
// S_HOLD  | word for PCF parked in the hold buffer, waiting for decode
// S_HALT  | program finished; only rst leaves this state
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_if.master       imem,
  input  logic               PCSrc,
  input  logic [31:0]        PCTarget,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               Finish_Prog,
  output logic [31:0]        InstrD,
  output logic [31:0]        PCD,
  output logic [31:0]        PCPlus4D,
  output logic               ValidD,
  output logic               Halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold;
  logic [31:0] r_instr;
  logic [31:0] r_pcd;
  logic [31:0] r_pcp4;
  logic        r_valid;
  logic        r_halted;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_hold_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pcd_nxt;
  logic [31:0] w_pcp4_nxt;
  logic        w_valid_nxt;
  logic        w_halted_nxt;

  logic [31:0] w_pc_plus4;
  logic        w_slot_free;

  // Modulo-2^32 increment; 0xFFFF_FFFC wraps to 0.
  assign w_pc_plus4  = r_pc + 32'd4;
  // A flush empties the slot, so decode can take a new word even if stalled.
  assign w_slot_free = ~Stall | Flush;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_hold   <= 32'd0;
      r_instr  <= NOP_INSTR;
      r_pcd    <= 32'd0;
      r_pcp4   <= 32'd0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_hold   <= w_hold_nxt;
      r_instr  <= w_instr_nxt;
      r_pcd    <= w_pcd_nxt;
      r_pcp4   <= w_pcp4_nxt;
      r_valid  <= w_valid_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: HALT > PCSrc > Finish_Prog > Flush/Stall > fetch
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_hold_nxt   = r_hold;
    w_instr_nxt  = r_instr;
    w_pcd_nxt    = r_pcd;
    w_pcp4_nxt   = r_pcp4;
    w_valid_nxt  = r_valid;
    w_halted_nxt = r_halted;

    case (r_state)
      S_HALT: begin
        // Frozen until reset.
      end

      default: begin
        if (PCSrc) begin
          // Redirect drops the slot, the parked word and any response
          // arriving this cycle for the old PC.
          w_pc_nxt    = PCTarget;
          w_valid_nxt = 1'b0;
          w_hold_nxt  = 32'd0;
          w_state_nxt = S_FETCH;
        end else if (Finish_Prog && r_valid) begin
          w_valid_nxt  = 1'b0;
          w_halted_nxt = 1'b1;
          w_state_nxt  = S_HALT;
        end else if (r_state == S_HOLD) begin
          if (w_slot_free) begin
            w_instr_nxt = r_hold;
            w_pcd_nxt   = r_pc;
            w_pcp4_nxt  = w_pc_plus4;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = S_FETCH;
          end
        end else if (imem.imem_ready) begin
          if (w_slot_free) begin
            w_instr_nxt = imem.imem_rdata;
            w_pcd_nxt   = r_pc;
            w_pcp4_nxt  = w_pc_plus4;
            w_valid_nxt = 1'b1;
            w_pc_nxt    = w_pc_plus4;
          end else begin
            // Decode is busy: park the word and stop requesting.
            w_hold_nxt  = imem.imem_rdata;
            w_state_nxt = S_HOLD;
          end
        end else begin
          // No response: slot keeps its instruction only if decode is stalled.
          if (w_slot_free) begin
            w_valid_nxt = 1'b0;
          end
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem.imem_req  = (r_state == S_FETCH);
  assign imem.imem_addr = r_pc;

  assign InstrD   = r_valid ? r_instr : NOP_INSTR;
  assign PCD      = r_pcd;
  assign PCPlus4D = r_pcp4;
  assign ValidD   = r_valid;
  assign Halted   = r_halted;

endmodule
